// File: rtl/ball_control.sv
// Ball motion for the breakout game: position/velocity registers, wall, paddle
// and brick bounces, serve, life loss and game-over sequencing.
module ball_control #(
  parameter logic [8:0] X_MIN       = 9'd8,
  parameter logic [8:0] X_MAX       = 9'd310,
  parameter logic [7:0] Y_MIN       = 8'd8,
  parameter logic [7:0] Y_LOST      = 8'd236,
  parameter logic [8:0] SERVE_X     = 9'd160,
  parameter logic [7:0] SERVE_Y     = 8'd200,
  parameter logic [1:0] LIVES       = 2'd3,
  parameter logic [5:0] LOST_FRAMES = 6'd60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       launch,
  input  logic [2:0] paddle_hit,
  input  logic       brick_hit,
  output logic [8:0] ball_x,
  output logic [7:0] ball_y,
  output logic       draw,
  output logic       ball_lost,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_LOST = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic signed [2:0] dx_q, dx_d;
  logic signed [1:0] dy_q, dy_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [8:0]        x_d;
  logic [7:0]        y_d;
  logic              draw_d, lost_d;
  logic [1:0]        lives_d;

  // 10-bit signed candidates so edge comparisons never see wrap-around.
  logic signed [9:0] nx, ny, ny_flip;
  assign nx      = $signed({1'b0, ball_x}) + $signed({{7{dx_q[2]}}, dx_q});
  assign ny      = $signed({2'b0, ball_y}) + $signed({{8{dy_q[1]}}, dy_q});
  assign ny_flip = $signed({2'b0, ball_y}) - $signed({{8{dy_q[1]}}, dy_q});

  assign state     = state_q;
  assign game_over = (state_q == S_OVER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ball_x    <= SERVE_X;
      ball_y    <= SERVE_Y;
      dx_q      <= 3'sd1;
      dy_q      <= -2'sd1;
      cnt_q     <= 6'd0;
      lives     <= LIVES;
      draw      <= 1'b1;
      ball_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x    <= x_d;
      ball_y    <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      lives     <= lives_d;
      draw      <= draw_d;
      ball_lost <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = ball_x;
    y_d     = ball_y;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    lives_d = lives;
    draw_d  = 1'b0;
    lost_d  = 1'b0;
    case (state_q)
      S_IDLE: if (launch) state_d = S_MOVE;
      S_MOVE: if (tick) begin
        draw_d = 1'b1;
        if (nx <= $signed({1'b0, X_MIN})) begin
          x_d  = X_MIN;
          dx_d = -dx_q;
        end else if (nx >= $signed({1'b0, X_MAX})) begin
          x_d  = X_MAX;
          dx_d = -dx_q;
        end else begin
          x_d = nx[8:0];
        end
        // A paddle hit while rising is ignored so the ball cannot bounce twice.
        if (paddle_hit != 3'd0 && dy_q == 2'sd1) begin
          dy_d = -2'sd1;
          y_d  = ball_y - 8'd1;
          case (paddle_hit)
            3'd1:    dx_d = -3'sd2;
            3'd2:    dx_d = -3'sd1;
            3'd3:    dx_d = dx_q[2] ? -3'sd1 : 3'sd1;
            3'd4:    dx_d = 3'sd1;
            3'd5:    dx_d = 3'sd2;
            default: ;
          endcase
        end else if (brick_hit) begin
          dy_d = -dy_q;
          y_d  = ny_flip[7:0];
        end else if (ny <= $signed({2'b0, Y_MIN})) begin
          y_d  = Y_MIN;
          dy_d = 2'sd1;
        end else if (ny >= $signed({2'b0, Y_LOST})) begin
          y_d     = ny[7:0];
          state_d = S_LOST;
          lost_d  = 1'b1;
          cnt_d   = 6'd0;
          lives_d = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
        end else begin
          y_d = ny[7:0];
        end
      end
      S_LOST: if (tick) begin
        if (cnt_q == LOST_FRAMES - 6'd1) begin
          cnt_d = 6'd0;
          if (lives == 2'd0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_IDLE;
            x_d     = SERVE_X;
            y_d     = SERVE_Y;
            dx_d    = 3'sd1;
            dy_d    = -2'sd1;
            draw_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_OVER:  ;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
